// File: rtl/ahb_sram_ctrl_if.sv
// AHB-Lite slave-side bus bundle for the SRAM controller.
// Signals: HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA/HREADY from master side,
//          HREADYOUT/HRESP/HRDATA returned by the slave.
interface ahb_sram_ctrl_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HREADY, HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave backing a word-organised SRAM; byte/half/word little-endian lanes.
// Latency: OKAY data phase = 1 + WAIT_STATES cycles; ERROR is always two cycles.
// Backpressure: own wait/error cycles drive HREADYOUT low; no address is taken while HREADY is low.
// Ports: HCLK, HRESETn (sync, active-low), bus (ahb_sram_ctrl_if.slave).
module ahb_sram_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    ahb_sram_ctrl_if.slave   bus
);
    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam int          OFF_W     = IDX_W + 2;
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [2:0]  WS        = 3'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t           r_state;
    logic [2:0]       r_cnt;
    logic             r_pend;     // a legal data phase is outstanding
    logic             r_wr;
    logic [1:0]       r_size;
    logic [OFF_W-1:0] r_off;
    logic             r_hreadyout;
    logic             r_hresp;
    logic [31:0]      r_hrdata;
    logic [31:0]      r_mem [DEPTH_WORDS];

    logic             w_accept;
    logic [31:0]      w_off;
    logic             w_illegal;
    logic             w_complete;
    logic             w_wr_en;
    logic [3:0]       w_be;
    logic [31:0]      w_mask;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic [31:0]      w_wr_word;
    logic [31:0]      w_fwd_word;

    assign w_accept = bus.HSEL && (bus.HTRANS == 2'b10 || bus.HTRANS == 2'b11) && bus.HREADY;
    assign w_off    = bus.HADDR - BASE_ADDR;

    assign w_illegal = (bus.HSIZE > 3'd2)
                     || (bus.HSIZE == 3'd1 && bus.HADDR[0])
                     || (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00)
                     || (bus.HADDR < BASE_ADDR)
                     || (w_off >= MEM_BYTES);

    // Data phase completes whenever a legal transfer is pending and we are ready
    // (only true in IDLE; ERR2 never has a pending legal transfer).
    assign w_complete = r_pend && r_hreadyout;
    assign w_wr_en    = w_complete && r_wr;

    always_comb begin
        w_be = 4'b1111;
        case (r_size)
            2'd0:    w_be = 4'b0001 << r_off[1:0];
            2'd1:    w_be = r_off[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < 4; i++) begin
            w_mask[8*i +: 8] = {8{w_be[i]}};
        end
    end

    assign w_wr_idx  = r_off[OFF_W-1:2];
    assign w_rd_idx  = w_off[OFF_W-1:2];
    assign w_wr_word = (r_mem[w_wr_idx] & ~w_mask) | (bus.HWDATA & w_mask);

    // A zero-wait read accepted on the same edge a write completes must see that write.
    assign w_fwd_word = (w_wr_en && (w_wr_idx == w_rd_idx)) ? w_wr_word : r_mem[w_rd_idx];

    always_ff @(posedge HCLK) begin
        if (HRESETn && w_wr_en) begin
            r_mem[w_wr_idx] <= w_wr_word;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_pend      <= 1'b0;
            r_wr        <= 1'b0;
            r_size      <= 2'd0;
            r_off       <= '0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_hrdata    <= 32'd0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (r_cnt == 3'd1) begin
                        r_state     <= S_IDLE;
                        r_hreadyout <= 1'b1;
                        // Sample read data so it is stable during the completion cycle.
                        if (!r_wr) begin
                            r_hrdata <= r_mem[w_wr_idx];
                        end
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_ERR1: begin
                    r_state     <= S_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b1;
                end
                default: begin
                    // IDLE and ERR2 both accept a new address phase.
                    r_state     <= S_IDLE;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b0;
                    r_pend      <= 1'b0;
                    if (w_accept) begin
                        if (w_illegal) begin
                            r_state     <= S_ERR1;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= 1'b1;
                        end else begin
                            r_pend <= 1'b1;
                            r_wr   <= bus.HWRITE;
                            r_size <= bus.HSIZE[1:0];
                            r_off  <= w_off[OFF_W-1:0];
                            if (WS == 3'd0) begin
                                if (!bus.HWRITE) begin
                                    r_hrdata <= w_fwd_word;
                                end
                            end else begin
                                r_state     <= S_WAIT;
                                r_cnt       <= WS;
                                r_hreadyout <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bus.HREADYOUT = r_hreadyout;
    assign bus.HRESP     = r_hresp;
    assign bus.HRDATA    = r_hrdata;
endmodule

// File: doc/ahb_sram_ctrl.md
# ahb_sram_ctrl

AHB-Lite slave that responds to the transfers issued by the SoC's AHB masters (RV32I core, DMA) through the shared master mux, backing a word-organised on-chip SRAM. It supports byte/halfword/word accesses with little-endian lane selection, pipelined address/data phases, a configurable number of wait states, and a two-cycle ERROR response for illegal accesses. It sits behind the address decoder on the SRAM select line.

## Interface
- BASE_ADDR, 32'h2000_0000, byte address of word 0
- DEPTH_WORDS, 1024, number of 32-bit words (power of two, ≥ 4)
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY data phase (0–7)

- HCLK  in  1  clock; one clock, everything on rising edge
- HRESETn  in  1  reset, synchronous and active-low
- HSEL  in  1  slave select from decoder
- HADDR  in  32  address phase address
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 byte, 1 half, 2 word
- HWDATA  in  32  write data, data phase
- HREADY  in  1  bus-level ready (previous transfer complete)
- HREADYOUT  out  1  this slave's ready
- HRESP  out  1  0 OKAY, 1 ERROR
- HRDATA  out  32  read data

## Operation
- Address phase accepted when HSEL & HTRANS[1] & HREADY at a rising edge; latch offset (HADDR−BASE_ADDR), HWRITE, HSIZE. IDLE/BUSY or HSEL=0 with HREADY: no access, next data phase zero-wait OKAY.
- Error check at acceptance, any one triggers ERROR: HSIZE>2; HSIZE=1 & HADDR[0]; HSIZE=2 & HADDR[1:0]≠0; HADDR<BASE_ADDR or offset ≥ DEPTH_WORDS*4.
- States: IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0. On legal accept: WAIT_STATES=0 → data phase completes next cycle (stay IDLE); else → WAIT with counter=WAIT_STATES. On illegal accept → ERR1.
  - WAIT: HREADYOUT=0, counter decrements each cycle; at 1 → IDLE (completion cycle has HREADYOUT=1).
  - ERR1: HREADYOUT=0, HRESP=1 → ERR2. ERR2: HREADYOUT=1, HRESP=1; accepts a new address phase like IDLE → next state per that transfer.
- Write: performed on the completion cycle of the data phase (HREADYOUT=1) using HWDATA; byte lane = offset[1:0] for bytes, offset[1]*2 for halves; other bytes untouched. Errored transfers never write.
- Read: HRDATA = full word at offset[..:2], valid on completion cycle; lanes not addressed carry the stored word bytes too. HRDATA holds last read value otherwise.
- Read data phase directly after a write to the same word returns the newly written bytes.

## Timing
- Reset (HRESETn low at edge): HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, pending transfer discarded (no write). SRAM contents not cleared.
- Reset mid-WAIT or mid-ERR: same as above on next edge, no write.
- OKAY latency: data phase = 1+WAIT_STATES cycles after address phase edge; back-to-back transfers at WAIT_STATES=0 sustain one per cycle.
- ERROR: always exactly two data-phase cycles regardless of WAIT_STATES.
- No new address accepted while HREADY low (own wait state stalls the bus).

## Test plan
- WAIT_STATES=0: write word 0xDEADBEEF @BASE+0x10, read back next cycle → HRDATA=0xDEADBEEF, HREADYOUT never low.
- Byte write 0x55 @BASE+0x13 over 0xDEADBEEF, read word → 0x55ADBEEF; halfword write 0x1234 @BASE+0x10 → 0x55AD1234.
- WAIT_STATES=3: word read → HREADYOUT low exactly 3 cycles, data on 4th data-phase cycle.
- Word @BASE+0x2 and address BASE+DEPTH_WORDS*4 → HRESP=1 with HREADYOUT 0 then 1; memory unchanged.
- BUSY/IDLE transfers with HSEL=1 → zero-wait OKAY, no write.
- HRESETn asserted during WAIT of a write → outputs reset values next edge, target word unchanged.
